decode_stage: RTL and testbench

- Instruction-decode pipeline stage that feeds the execute-stage ALU.
- Holds the 32x32 register file and decodes a MIPS-subset instruction word into an ALU function code, operands and memory/branch/writeback controls.
- Registers the result into an ID/EX output bundle with a valid/ready handshake, stall and flush.
- Sits between the fetch stage and the execute stage; its outputs drive alu_func, a and b on the ALU directly.

---
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: 32x32 register file, MIPS-subset decoder and a
// registered ID/EX bundle behind a valid/ready handshake with stall and flush.
package func;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {add, sub, land, lor, lnor, slt} func_t;

  typedef struct packed {
    func_t       f;
    word_t       a;
    word_t       b;
    word_t       sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        il;
  } bundle_t;
endpackage

module decode_stage
  import func::*;
#(
  parameter int unsigned NREGS      = 32,
  parameter func_t       RESET_FUNC = add
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  word_t       wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output func_t       alu_func,
  output word_t       a,
  output word_t       b,
  output word_t       store_data,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal
);

  word_t   rf_q [NREGS];
  logic    valid_q;
  bundle_t bundle_q;
  bundle_t dec;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  word_t       rs_val;
  word_t       rt_val;
  word_t       simm;
  word_t       zimm;
  logic        accept;
  logic        unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign unused_shamt = ^instr[10:6];
  assign simm         = {{16{imm[15]}}, imm};
  assign zimm         = {16'h0000, imm};

  assign in_ready = out_ready | ~valid_q;
  assign accept   = in_valid & in_ready;

  // Same-cycle writeback is forwarded so the bundle never carries a stale operand.
  always_comb begin
    rs_val = '0;
    if (rs != '0) rs_val = (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
    rt_val = '0;
    if (rt != '0) rt_val = (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
  end

  always_comb begin
    dec      = '0;
    dec.f    = RESET_FUNC;
    dec.a    = rs_val;
    dec.b    = rt_val;
    dec.sd   = rt_val;
    unique case (opcode)
      6'h00: begin
        dec.dest = rd;
        dec.rw   = 1'b1;
        unique case (funct)
          6'h20:   dec.f = add;
          6'h22:   dec.f = sub;
          6'h24:   dec.f = land;
          6'h25:   dec.f = lor;
          6'h27:   dec.f = lnor;
          6'h2A:   dec.f = slt;
          default: begin
            dec.dest = '0;
            dec.rw   = 1'b0;
            dec.il   = 1'b1;
          end
        endcase
      end
      6'h08: begin dec.f = add;  dec.b = simm; dec.dest = rt; dec.rw = 1'b1; end
      6'h0A: begin dec.f = slt;  dec.b = simm; dec.dest = rt; dec.rw = 1'b1; end
      6'h0C: begin dec.f = land; dec.b = zimm; dec.dest = rt; dec.rw = 1'b1; end
      6'h0D: begin dec.f = lor;  dec.b = zimm; dec.dest = rt; dec.rw = 1'b1; end
      6'h23: begin
        dec.f = add; dec.b = simm; dec.dest = rt; dec.rw = 1'b1; dec.mr = 1'b1;
      end
      6'h2B: begin dec.f = add; dec.b = simm; dec.dest = rt; dec.mw = 1'b1; end
      6'h04: begin dec.f = sub; dec.dest = rt; dec.br = 1'b1; end
      default: dec.il = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q       <= '{default: '0};
      valid_q    <= 1'b0;
      bundle_q   <= '0;
      bundle_q.f <= RESET_FUNC;
    end else begin
      if (wb_en && wb_addr != '0) rf_q[wb_addr] <= wb_data;
      // Bubbles keep operand data but clear every control enable.
      if (flush || (!accept && out_ready)) begin
        valid_q     <= 1'b0;
        bundle_q.f  <= RESET_FUNC;
        bundle_q.rw <= 1'b0;
        bundle_q.mr <= 1'b0;
        bundle_q.mw <= 1'b0;
        bundle_q.br <= 1'b0;
        bundle_q.il <= 1'b0;
      end else if (accept) begin
        valid_q  <= 1'b1;
        bundle_q <= dec;
      end
    end
  end

  assign out_valid  = valid_q;
  assign alu_func   = bundle_q.f;
  assign a          = bundle_q.a;
  assign b          = bundle_q.b;
  assign store_data = bundle_q.sd;
  assign dest       = bundle_q.dest;
  assign reg_write  = bundle_q.rw;
  assign mem_read   = bundle_q.mr;
  assign mem_write  = bundle_q.mw;
  assign branch     = bundle_q.br;
  assign illegal    = bundle_q.il;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected
// bundles; a negedge monitor pops and compares on every output transfer.
module tb_decode_stage;
  import func::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  word_t       wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  func_t       alu_func;
  word_t       a, b, store_data;
  logic [4:0]  dest;
  logic        reg_write, mem_read, mem_write, branch, illegal;

  typedef struct {
    func_t       f;
    logic [31:0] a, b, sd;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, il;
    logic        ctrl_only;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  decode_stage #(.NREGS(32), .RESET_FUNC(add)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_func(alu_func), .a(a), .b(b), .store_data(store_data), .dest(dest),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(func_t f, logic [31:0] ea, logic [31:0] eb,
                              logic [31:0] esd, logic [4:0] ed, logic rw,
                              logic mr, logic mw, logic br, logic il, logic co);
    exp_t e;
    e.f = f; e.a = ea; e.b = eb; e.sd = esd; e.dest = ed;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.il = il; e.ctrl_only = co;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [31:0] ins, exp_t e, bit push);
    int n = 0;
    in_valid = 1'b1;
    instr    = ins;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("issue_timeout", 32'd0, 32'd1);
    if (push) sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: a transfer is out_valid & out_ready with no flush killing it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bundle: got func=%0d a=0x%08h dest=%0d expected none",
                 alu_func, a, dest);
      end else begin
        exp_t e;
        bit   bad;
        e   = sb.pop_front();
        bad = (alu_func !== e.f) || (reg_write !== e.rw) || (mem_read !== e.mr) ||
              (mem_write !== e.mw) || (branch !== e.br) || (illegal !== e.il);
        if (!e.ctrl_only)
          bad = bad || (a !== e.a) || (b !== e.b) || (store_data !== e.sd) || (dest !== e.dest);
        if (bad) begin
          failures++;
          $display("FAIL bundle: got f=%0d a=%08h b=%08h sd=%08h d=%0d rw%b mr%b mw%b br%b il%b expected f=%0d a=%08h b=%08h sd=%08h d=%0d rw%b mr%b mw%b br%b il%b",
                   alu_func, a, b, store_data, dest, reg_write, mem_read, mem_write, branch, illegal,
                   e.f, e.a, e.b, e.sd, e.dest, e.rw, e.mr, e.mw, e.br, e.il);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_func", {29'd0, alu_func}, {29'd0, add});
    chk("rst_a", a, 32'd0);
    chk("rst_ctrl", {27'd0, reg_write, mem_read, mem_write, branch, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; step();
    wb_addr = 5'd2; wb_data = 32'd3; step();
    wb_en = 1'b0;

    issue(32'h00221820, mk(add, 32'd5, 32'd3, 32'd3, 5'd3, 1, 0, 0, 0, 0, 0), 1);
    step();
    chk("drop_after_accept", {31'd0, out_valid}, 32'd0);

    issue(32'h2024FFFF, mk(add, 32'd5, 32'hFFFFFFFF, 32'd0, 5'd4, 1, 0, 0, 0, 0, 0), 1);
    issue(32'h34248000, mk(lor, 32'd5, 32'h00008000, 32'd0, 5'd4, 1, 0, 0, 0, 0, 0), 1);

    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h77;
    issue(32'h00222822, mk(sub, 32'h77, 32'd3, 32'd3, 5'd5, 1, 0, 0, 0, 0, 0), 1);
    wb_addr = 5'd0; wb_data = 32'h55; step();
    issue(32'h00003820, mk(add, 32'd0, 32'd0, 32'd0, 5'd7, 1, 0, 0, 0, 0, 0), 1);
    wb_en = 1'b0;
    issue(32'h00003020, mk(add, 32'd0, 32'd0, 32'd0, 5'd6, 1, 0, 0, 0, 0, 0), 1);

    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd9;
    issue(32'h0041402A, mk(slt, 32'd9, 32'h77, 32'h77, 5'd8, 1, 0, 0, 0, 0, 0), 1);
    wb_en = 1'b0;
    issue(32'h3049FFFF, mk(land, 32'd9, 32'h0000FFFF, 32'd0, 5'd9, 1, 0, 0, 0, 0, 0), 1);
    issue(32'h282AFFFE, mk(slt, 32'h77, 32'hFFFFFFFE, 32'd0, 5'd10, 1, 0, 0, 0, 0, 0), 1);
    issue(32'h8C4B0004, mk(add, 32'd9, 32'd4, 32'd0, 5'd11, 1, 1, 0, 0, 0, 0), 1);
    issue(32'hAC41FFF8, mk(add, 32'd9, 32'hFFFFFFF8, 32'h77, 5'd1, 0, 0, 1, 0, 0, 0), 1);
    issue(32'h00226025, mk(lor, 32'h77, 32'd9, 32'd9, 5'd12, 1, 0, 0, 0, 0, 0), 1);
    issue(32'h00226827, mk(lnor, 32'h77, 32'd9, 32'd9, 5'd13, 1, 0, 0, 0, 0, 0), 1);
    issue(32'h00227024, mk(land, 32'h77, 32'd9, 32'd9, 5'd14, 1, 0, 0, 0, 0, 0), 1);
    issue(32'h10220010, mk(sub, 32'h77, 32'd9, 32'd9, 5'd2, 0, 0, 0, 1, 0, 0), 1);
    issue(32'hFC000000, mk(add, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1, 1), 1);
    issue(32'h00221821, mk(add, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1, 1), 1);
    step();

    // Stall: held bundle must stay put while a pending sub waits.
    out_ready = 1'b0;
    issue(32'h00221820, mk(add, 32'h77, 32'd9, 32'd9, 5'd3, 1, 0, 0, 0, 0, 0), 1);
    in_valid = 1'b1; instr = 32'h00222822;
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_a", a, 32'h77);
      chk("stall_dest", {27'd0, dest}, 32'd3);
      step();
    end
    out_ready = 1'b1; #1;
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back(mk(sub, 32'h77, 32'd9, 32'd9, 5'd5, 1, 0, 0, 0, 0, 0));
    step();
    in_valid = 1'b0;
    step();

    // Flush kills held beq and incoming lw; the writeback still lands.
    out_ready = 1'b0;
    issue(32'h10220010, mk(sub, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0);
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h8C4B0004; flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAB;
    step();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ctrl", {27'd0, reg_write, mem_read, mem_write, branch, illegal}, 32'd0);
    step();
    chk("flush_no_lw", {31'd0, out_valid}, 32'd0);
    issue(32'h00607820, mk(add, 32'hAB, 32'd0, 32'd0, 5'd15, 1, 0, 0, 0, 0, 0), 1);
    step();

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    issue(32'h00221820, mk(add, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    chk("prerst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_a", a, 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    issue(32'h00228020, mk(add, 32'd0, 32'd0, 32'd0, 5'd16, 1, 0, 0, 0, 0, 0), 1);
    step(); step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
